bitbrick_slice_sequencer: RTL and testbench
===========================================

# bitbrick_slice_sequencer

Sequential slice issuer and shift-add recombiner for one bitbrick multiplier. It accepts a 2/4/8-bit × 2/4/8-bit operand pair over a valid/ready handshake. Each BUSY cycle it decomposes the operands into 2-bit slice pairs, drives them with sign flags into a single bitbrick, and accumulates the 6-bit signed partial products with the correct shift. The final 16-bit product is presented on a valid/ready output. It is the feeding and recombining end of the bitbrick slice interface, used where area matters more than throughput.

## Interface
- No parameters. Widths are fixed: operands 8 bits, product 16 bits, slice 2 bits.
- `clk` input 1: sole clock; all state changes on rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: operand pair offered.
- `in_ready` output 1: block can accept; high only in IDLE.
- `x` input 8: multiplicand; only the low `w(prec_x)` bits are used, upper bits ignored.
- `y` input 8: multiplier; only the low `w(prec_y)` bits are used, upper bits ignored.
- `sign_x` input 1: x is two's complement at its precision.
- `sign_y` input 1: y is two's complement at its precision.
- `prec_x` input 2: 00 = 2-bit, 01 = 4-bit, 10 = 8-bit, 11 treated as 8-bit.
- `prec_y` input 2: same encoding as `prec_x`.
- `out_valid` output 1: product available; high only in DONE.
- `out_ready` input 1: consumer takes the product.
- `p` output 16: product, two's complement when either sign flag is set, else unsigned.

## Operation
- States:
  - IDLE → BUSY on `in_valid & in_ready`.
  - BUSY → DONE after the last slice pair.
  - DONE → IDLE on `out_valid & out_ready`.
  - No accept in DONE; no back-to-back overlap.
- On accept:
  - register masked x and y, both sign flags, and `nx = w(prec_x)/2`, `ny = w(prec_y)/2`;
  - clear the accumulator;
  - clear slice indices i (y) and j (x).
- Each BUSY cycle processes one slice pair:
  - bitbrick inputs are x slice j and y slice i;
  - the x sign flag to the bitbrick is `sign_x & (j == nx-1)`;
  - the y sign flag to the bitbrick is `sign_y & (i == ny-1)`.
- Partial product arithmetic:
  - bitbrick output is a 6-bit two's complement value;
  - sign-extend it to 16 bits, shift left by 2·(i+j), and add to the accumulator modulo 2^16.
- Iteration order: j inner, i outer. When j = nx-1, j wraps to 0 and i increments. When both indices are at their last value, go to DONE.
- Modulo-2^16 accumulation is exact, because every legal product fits in 16 bits.
- `p` is the accumulator register. It holds stable throughout DONE regardless of input activity.
- Reset values: state IDLE, `in_ready` = 1, `out_valid` = 0, `p` = 0, indices 0.
- Reset asserted mid-BUSY or mid-DONE aborts the operation and the product is discarded. The block is in IDLE in the cycle after the reset edge.
- Inputs are sampled only on the accept edge. Changes to `x`, `y`, sign or precision inputs during BUSY or DONE have no effect.

## Timing
- Let N = nx·ny, giving 1, 2, 4, 8 or 16.
- Accept at edge E0. `out_valid` is high after edge EN, i.e. N cycles of BUSY.
- `out_valid` stays high until the edge where `out_ready` = 1. `in_ready` rises after that same edge.
- Minimum issue interval: N+2 cycles (accept, N BUSY, ≥1 DONE).
- The bitbrick is combinational. The accumulate path is bitbrick, shift and a 16-bit add within one cycle.

## Configuration
- `BB_SEQ_ZERO_SKIP_EN` defined:
  - if masked x == 0 or masked y == 0 at accept, go IDLE → DONE directly with `p` = 0;
  - `out_valid` is then high after E0.
- `BB_SEQ_ZERO_SKIP_EN` undefined: every operation takes the full N BUSY cycles, with zero operands included.

## Structure
- Shared package `bitbrick_pkg` holds:
  - the state enum (IDLE, BUSY, DONE);
  - precision codes PREC_2, PREC_4, PREC_8;
  - constants SLICE_W = 2, OP_W = 8, PROD_W = 16, PP_W = 6.
- One sub-module: a `bitbrick` instance driven by the slice mux.
- Slice selection, index counters and the accumulator stay in this block.

## Test plan
- **2×2 signed:** x=2'b11, sign_x=1, y=2'b01, sign_y=0 → N=1; `p`=16'hFFFF with `out_valid` after E1.
- **8×8 signed:** x=8'h80, y=8'h80, both signs set → `p`=16'h4000 after E16.
- **8×8 unsigned:** x=8'hFF, y=8'hFF → `p`=16'hFE01.
- **4×8 mixed:** prec_x=4-bit, x=8'hAF (upper nibble junk), sign_x=1; y=8'h7F unsigned → `p`=16'hFF81 after E8.
- **Backpressure:** `out_ready` low for 5 cycles → `out_valid`, `p` and `in_ready`=0 stay stable. Then apply reset mid-BUSY → next cycle `out_valid`=0, `in_ready`=1, `p`=0.
- **Zero operand:** x=0, 8×8 → `out_valid` after E0 with `BB_SEQ_ZERO_SKIP_EN` defined, after E16 without; `p`=0 in both cases.

Source files
------------

// File: rtl/bitbrick_pkg.sv
// Shared types and constants for the bitbrick slice sequencer.
package bitbrick_pkg;

    localparam int unsigned SLICE_W = 2;
    localparam int unsigned OP_W    = 8;
    localparam int unsigned PROD_W  = 16;
    localparam int unsigned PP_W    = 6;

    localparam logic [1:0] PREC_2 = 2'b00;
    localparam logic [1:0] PREC_4 = 2'b01;
    localparam logic [1:0] PREC_8 = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Index of the last 2-bit slice at a given precision (code 11 acts as 8-bit).
    function automatic logic [1:0] last_idx(input logic [1:0] prec);
        case (prec)
            PREC_2:  last_idx = 2'd0;
            PREC_4:  last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    endfunction

    function automatic logic [OP_W-1:0] prec_mask(input logic [1:0] prec);
        case (prec)
            PREC_2:  prec_mask = 8'h03;
            PREC_4:  prec_mask = 8'h0F;
            default: prec_mask = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/bitbrick.sv
// Combinational 2x2 bitbrick: each slice is signed or unsigned per its flag; 6-bit signed product.
module bitbrick
    import bitbrick_pkg::*;
(
    input  logic [SLICE_W-1:0] x_i,
    input  logic [SLICE_W-1:0] y_i,
    input  logic               sx_i,
    input  logic               sy_i,
    output logic [PP_W-1:0]    pp_o
);

    logic signed [PP_W-1:0] x_ext;
    logic signed [PP_W-1:0] y_ext;

    assign x_ext = {{(PP_W-SLICE_W){sx_i & x_i[SLICE_W-1]}}, x_i};
    assign y_ext = {{(PP_W-SLICE_W){sy_i & y_i[SLICE_W-1]}}, y_i};
    assign pp_o  = x_ext * y_ext;

endmodule

// File: rtl/bitbrick_slice_sequencer.sv
// Issues 2-bit slice pairs into one bitbrick and shift-adds the partial products.
// Optional BB_SEQ_ZERO_SKIP_EN: zero operands bypass BUSY and finish with p = 0.
module bitbrick_slice_sequencer
    import bitbrick_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   x,
    input  logic [OP_W-1:0]   y,
    input  logic              sign_x,
    input  logic              sign_y,
    input  logic [1:0]        prec_x,
    input  logic [1:0]        prec_y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] p
);

    state_e            state_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [OP_W-1:0]   x_q;
    logic [OP_W-1:0]   y_q;
    logic              sx_q;
    logic              sy_q;
    logic [1:0]        jlast_q;
    logic [1:0]        ilast_q;
    logic [1:0]        i_q;
    logic [1:0]        j_q;
    logic [PROD_W-1:0] acc_q;

    logic [OP_W-1:0]    x_m;
    logic [OP_W-1:0]    y_m;
    logic [SLICE_W-1:0] x_slice;
    logic [SLICE_W-1:0] y_slice;
    logic               bb_sx;
    logic               bb_sy;
    logic [PP_W-1:0]    pp;
    logic [PROD_W-1:0]  pp_ext;
    logic [3:0]         shamt;
    logic [PROD_W-1:0]  acc_d;

    assign x_m = x & prec_mask(prec_x);
    assign y_m = y & prec_mask(prec_y);

    // Slice mux; sign only applies to the most significant slice of a signed operand.
    assign x_slice = x_q[{j_q, 1'b0} +: SLICE_W];
    assign y_slice = y_q[{i_q, 1'b0} +: SLICE_W];
    assign bb_sx   = sx_q & (j_q == jlast_q);
    assign bb_sy   = sy_q & (i_q == ilast_q);

    bitbrick u_bitbrick (
        .x_i  (x_slice),
        .y_i  (y_slice),
        .sx_i (bb_sx),
        .sy_i (bb_sy),
        .pp_o (pp)
    );

    assign pp_ext = {{(PROD_W-PP_W){pp[PP_W-1]}}, pp};
    assign shamt  = {3'({1'b0, i_q} + {1'b0, j_q}), 1'b0};
    assign acc_d  = acc_q + (pp_ext << shamt);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            sx_q        <= 1'b0;
            sy_q        <= 1'b0;
            jlast_q     <= '0;
            ilast_q     <= '0;
            i_q         <= '0;
            j_q         <= '0;
            acc_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        x_q        <= x_m;
                        y_q        <= y_m;
                        sx_q       <= sign_x;
                        sy_q       <= sign_y;
                        jlast_q    <= last_idx(prec_x);
                        ilast_q    <= last_idx(prec_y);
                        i_q        <= '0;
                        j_q        <= '0;
                        acc_q      <= '0;
                        in_ready_q <= 1'b0;
`ifdef BB_SEQ_ZERO_SKIP_EN
                        if (x_m == '0 || y_m == '0) begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_BUSY;
                        end
`else
                        state_q <= ST_BUSY;
`endif
                    end
                end
                ST_BUSY: begin
                    acc_q <= acc_d;
                    if (j_q == jlast_q) begin
                        j_q <= '0;
                        if (i_q == ilast_q) begin
                            i_q         <= '0;
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            i_q <= 2'(i_q + 2'd1);
                        end
                    end else begin
                        j_q <= 2'(j_q + 2'd1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign p         = acc_q;

endmodule

// File: tb/tb_bitbrick_slice_sequencer.sv
// Directed-vector bench for bitbrick_slice_sequencer with hand-computed products and latencies.
module tb_bitbrick_slice_sequencer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        sign_x;
    logic        sign_y;
    logic [1:0]  prec_x;
    logic [1:0]  prec_y;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] p;

    int n_checks;
    int n_fail;

    bitbrick_slice_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .sign_x    (sign_x),
        .sign_y    (sign_y),
        .prec_x    (prec_x),
        .prec_y    (prec_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand pair, scramble inputs while busy, then check latency, product and handshake.
    task automatic run_op(input string tag, input logic [7:0] xv, input logic [7:0] yv,
                          input logic sx, input logic sy, input logic [1:0] px, input logic [1:0] py,
                          input logic [15:0] exp_p, input int exp_lat);
        int cnt;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        x = xv; y = yv; sign_x = sx; sign_y = sy; prec_x = px; prec_y = py;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        x = 8'($urandom); y = 8'($urandom);
        sign_x = ~sx; sign_y = ~sy; prec_x = ~px; prec_y = ~py;
        cnt = 0;
        while (!out_valid && cnt < 64) begin
            tick();
            cnt++;
        end
        check({tag, "_latency"}, 32'(cnt), 32'(exp_lat));
        check({tag, "_p"}, 32'(p), 32'(exp_p));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_release"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        int cnt;
        int zero_lat;
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        x = '0; y = '0; sign_x = 1'b0; sign_y = 1'b0; prec_x = 2'b00; prec_y = 2'b00;
        tick(); tick();
        reset = 1'b0;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_p", 32'(p), 32'd0);

        run_op("s2x2",  8'h03, 8'h01, 1'b1, 1'b0, 2'b00, 2'b00, 16'hFFFF, 1);
        run_op("s8x8",  8'h80, 8'h80, 1'b1, 1'b1, 2'b10, 2'b10, 16'h4000, 16);
        run_op("u8x8",  8'hFF, 8'hFF, 1'b0, 1'b0, 2'b10, 2'b10, 16'hFE01, 16);
        run_op("m4x8",  8'hAF, 8'h7F, 1'b1, 1'b0, 2'b01, 2'b10, 16'hFF81, 8);
        run_op("s4x4",  8'h08, 8'h07, 1'b1, 1'b1, 2'b01, 2'b01, 16'hFFC8, 4);
        run_op("m2x8",  8'hFE, 8'h81, 1'b0, 1'b1, 2'b00, 2'b11, 16'hFF02, 4);
`ifdef BB_SEQ_ZERO_SKIP_EN
        zero_lat = 0;
`else
        zero_lat = 16;
`endif
        run_op("zero",  8'h00, 8'h5A, 1'b0, 1'b0, 2'b10, 2'b10, 16'h0000, zero_lat);

        // Backpressure: product, out_valid and in_ready hold while inputs churn.
        x = 8'hFF; y = 8'hFF; sign_x = 1'b0; sign_y = 1'b0; prec_x = 2'b10; prec_y = 2'b10;
        in_valid = 1'b1;
        tick();
        cnt = 0;
        while (!out_valid && cnt < 64) begin
            tick();
            cnt++;
        end
        check("bp_latency", 32'(cnt), 32'd16);
        for (int k = 0; k < 5; k++) begin
            x = 8'($urandom); y = 8'($urandom); sign_x = ~sign_x;
            tick();
            check("bp_hold", {15'd0, out_valid, in_ready, p}, {15'd0, 1'b1, 1'b0, 16'hFE01});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release", {30'd0, out_valid, in_ready}, 32'b01);

        // Reset mid-BUSY discards the operation.
        x = 8'hFF; y = 8'hFF; sign_x = 1'b0; sign_y = 1'b0; prec_x = 2'b10; prec_y = 2'b10;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        check("busy_not_done", 32'(out_valid), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_busy", {15'd0, out_valid, in_ready, p}, {15'd0, 1'b0, 1'b1, 16'h0000});
        tick();
        check("rst_idle_stays", {30'd0, out_valid, in_ready}, 32'b01);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
